// File: rtl/rx_serial_7o1.sv
// 7O1 UART receiver: 7 data bits LSB first, odd parity, one stop bit, one-word holding register.
// Define RX_MAJORITY_EN to take each sample as a 3-point majority vote (needs CLKS_PER_BIT >= 6).
module rx_serial_7o1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    input  logic       le,
    output logic [6:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic       overrun,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        INICIAL     = 3'd0,
        START       = 3'd1,
        DADOS       = 3'd2,
        PARIDADE    = 3'd3,
        STOP        = 3'd4,
        REGISTRA    = 3'd5,
        ESPERA_ALTO = 3'd6
    } state_t;

    localparam int HALF = CLKS_PER_BIT / 2;

    // With majority voting the decision lands one cycle after the nominal point, so the
    // counter restarts at 1 to keep the next nominal point exactly one bit period later.
`ifdef RX_MAJORITY_EN
    localparam int ADV = 1;
`else
    localparam int ADV = 0;
`endif

    localparam logic [CNT_W-1:0] START_PT   = CNT_W'(HALF - 1 + ADV);
    localparam logic [CNT_W-1:0] BIT_PT     = CNT_W'(CLKS_PER_BIT - 1 + ADV);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(ADV);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [6:0]       shift_reg;
    logic             par_reg;
    logic             sync1_reg;
    logic             sync2_reg;
    logic             rx_s;
    logic             sample_bit;
    logic             parity_err;
    logic             stop_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= RX;
            sync2_reg <= sync1_reg;
        end
    end

    assign rx_s = sync2_reg;

`ifdef RX_MAJORITY_EN
    logic [1:0] hist_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_reg <= 2'b11;
        end else begin
            hist_reg <= {hist_reg[0], rx_s};
        end
    end

    assign sample_bit = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rx_s) | (hist_reg[0] & rx_s);
`else
    assign sample_bit = rx_s;
`endif

    // Odd parity: the 7 data bits plus the parity bit must contain an odd number of ones.
    assign parity_err = ~(^shift_reg ^ par_reg);
    assign stop_err   = ~sample_bit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= INICIAL;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            par_reg       <= 1'b0;
            dados_ascii   <= '0;
            pronto        <= 1'b0;
            tem_dado      <= 1'b0;
            erro_paridade <= 1'b0;
            erro_stop     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            pronto  <= 1'b0;
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (le) begin
                tem_dado <= 1'b0;
            end

            case (state_reg)
                INICIAL: begin
                    if (!rx_s) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (cnt_reg == START_PT) begin
                        cnt_reg     <= CNT_RELOAD;
                        bit_idx_reg <= '0;
                        state_reg   <= sample_bit ? INICIAL : DADOS;
                    end
                end
                DADOS: begin
                    if (cnt_reg == BIT_PT) begin
                        cnt_reg   <= CNT_RELOAD;
                        shift_reg <= {sample_bit, shift_reg[6:1]};
                        if (bit_idx_reg == 3'd6) begin
                            state_reg <= PARIDADE;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end
                end
                PARIDADE: begin
                    if (cnt_reg == BIT_PT) begin
                        cnt_reg   <= CNT_RELOAD;
                        par_reg   <= sample_bit;
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    // Results are registered on entry so they are visible during REGISTRA.
                    if (cnt_reg == BIT_PT) begin
                        cnt_reg       <= '0;
                        state_reg     <= REGISTRA;
                        erro_paridade <= parity_err;
                        erro_stop     <= stop_err;
                        if (!parity_err && !stop_err) begin
                            dados_ascii <= shift_reg;
                            pronto      <= 1'b1;
                            tem_dado    <= 1'b1;
                            overrun     <= overrun | (tem_dado & ~le);
                        end
                    end
                end
                REGISTRA: begin
                    cnt_reg   <= '0;
                    state_reg <= erro_stop ? ESPERA_ALTO : INICIAL;
                end
                ESPERA_ALTO: begin
                    if (rx_s) begin
                        cnt_reg   <= '0;
                        state_reg <= INICIAL;
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= INICIAL;
                end
            endcase
        end
    end

    assign db_estado = state_reg;

endmodule

// File: doc/rx_serial_7o1.md
Name: rx_serial_7O1

Overview:
- UART receiver for the 7-data-bit, odd-parity, 1-stop-bit format (7O1) that the tank controller's transmitter already uses.
- Sits directly upstream of the serial-reception controller that sets the level thresholds and the manual valve command.
- Converts the asynchronous RX pin into validated 7-bit ASCII characters with a one-word holding register and a read handshake.
- Reports parity, framing and overrun errors.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud); legal values ≥ 4.
CNT_W, 9, counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clock  input  1  system clock, 50 MHz.
reset  input  1  asynchronous, active-low reset.
RX  input  1  serial line, idle high, asynchronous to clock.
le  input  1  consumer has read dados_ascii; clears tem_dado.
dados_ascii  output  7  last valid character received.
pronto  output  1  one-cycle pulse when a valid character is stored.
tem_dado  output  1  holding register contains an unread character.
erro_paridade  output  1  last completed frame had bad parity.
erro_stop  output  1  last completed frame had stop bit = 0.
overrun  output  1  sticky; a valid frame arrived while tem_dado = 1.
db_estado  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset (reset = 0, asynchronous):
  - dados_ascii = 0; pronto = 0; tem_dado = 0; erro_paridade = 0; erro_stop = 0; overrun = 0.
  - Synchronizer flops = 1; bit counter = 0; FSM = INICIAL.
  - A reset asserted mid-frame discards that frame.
- RX passes through a 2-flop synchronizer (rx_s). All FSM decisions use rx_s only.
- Cycle counter `cnt`:
  - Cleared on every state transition.
  - Otherwise increments each cycle.
  - HALF = CLKS_PER_BIT/2, using integer division.
- FSM states and transitions:
  - INICIAL: rx_s = 0 → START.
  - START: at cnt = HALF-1, sample rx_s.
    - rx_s = 0 → DADOS, with bit index = 0.
    - rx_s = 1 → false start, return to INICIAL; no flags change.
  - DADOS: at cnt = CLKS_PER_BIT-1, shift rx_s into the data shift register, LSB first.
    - After the 7th bit → PARIDADE.
  - PARIDADE: at cnt = CLKS_PER_BIT-1, sample the parity bit → STOP.
  - STOP: at cnt = CLKS_PER_BIT-1, sample the stop bit → REGISTRA.
  - REGISTRA: lasts exactly one cycle.
    - erro_paridade = NOT (XOR of the 7 data bits and the parity bit).
    - erro_stop = NOT stop bit.
    - If both are 0:
      - dados_ascii is loaded.
      - pronto = 1 for this single cycle.
      - tem_dado = 1.
      - overrun is set if tem_dado was already 1. The new data overwrites the old.
    - If either error is set, dados_ascii and tem_dado are unchanged.
    - Next state: ESPERA_ALTO if the stop bit = 0, otherwise INICIAL.
  - ESPERA_ALTO: wait until rx_s = 1, then → INICIAL. This keeps a break condition from being taken as a new start bit.
- Latency:
  - Stop-bit sample occurs HALF + 9·CLKS_PER_BIT cycles after the cycle in which INICIAL sees rx_s = 0.
  - pronto follows in the next cycle.
  - The RX pin-to-rx_s delay is 2 cycles.
- Error flags hold their value until the end of the next completed frame. A false start does not change them.
- overrun is cleared only by reset.
- Handshake on `le`:
  - le = 1 clears tem_dado on the next edge.
  - If le = 1 in the same cycle as a valid REGISTRA, the set wins: tem_dado stays 1, and overrun is not set because the old word was consumed.
  - le while tem_dado = 0 has no effect.
- Back-to-back frames: a start bit immediately after the stop bit is accepted. REGISTRA takes one cycle and falls within the stop bit's second half.

Optional Feature:
RX_MAJORITY_EN
- Defined:
  - Every sample (start, data, parity, stop) is the majority of rx_s at cnt = T-1, T and T+1, where T is the nominal sample cycle.
  - State advance happens at T+1, and cnt continues the bit timing without accumulated drift: the next nominal point stays CLKS_PER_BIT after the previous one.
  - Requires CLKS_PER_BIT ≥ 6.
- Undefined: a single sample is taken at T as described above.
- Ports are identical in both cases.

Test Plan:
- All tests use CLKS_PER_BIT = 8.
- Send 'A' (data 1000001, parity 1, stop 1) → one pronto pulse, dados_ascii = 7'h41, tem_dado = 1, both error flags 0.
- Send '#' (7'h23) with parity 1 (wrong) → no pronto, erro_paridade = 1, dados_ascii keeps its prior value, tem_dado unchanged.
- Send '5' (7'h35, parity 1) with stop = 0 and RX held low for 20 bit times, then released → erro_stop = 1, FSM remains in ESPERA_ALTO until RX high, no spurious frame.
- Pulse RX low for 3 cycles only → FSM returns to INICIAL from START, no flag changes.
- Send 'A' then '5' back-to-back with no le → second pronto occurs, dados_ascii = 7'h35, overrun = 1. Then le = 1 → tem_dado = 0, overrun stays 1.
- Assert reset mid-DADOS, release, send 'A' → all outputs 0 during reset, then a clean reception of 7'h41.
